i2c_init_sequencer: RTL
=======================

I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 SHALL have parameter PERIPH_ADDR, default 7'h1A: 7-bit target address for every write.
REQ-002 SHALL have parameter NUM_WRITES, default 10: table entries to issue, range 1..16.
REQ-003 SHALL have parameter MAX_RETRIES, default 3: attempts per entry before abort.
REQ-004 SHALL have parameter GAP_CYCLES, default 16: idle cycles between transactions, range 1..255.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096: limit on the wait for transaction completion.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: request to run the init table.
REQ-009 SHALL have port txn_req, output, 1: write-transaction request to the I2C master.
REQ-010 SHALL have port txn_ready, input, 1: master can accept a request.
REQ-011 SHALL have port txn_addr, output, 7: equals PERIPH_ADDR.
REQ-012 SHALL have port txn_data, output, 16: {reg byte, data byte} for the current entry.
REQ-013 SHALL have port txn_done, input, 1: one-cycle pulse at transaction end.
REQ-014 SHALL have port txn_nack, input, 1: qualifies txn_done; 1 means NACK.
REQ-015 SHALL have port busy, output, 1: sequence in progress.
REQ-016 SHALL have port done, output, 1: all entries acknowledged; level output.
REQ-017 SHALL have port error, output, 1: sequence aborted; level output.
REQ-018 SHALL have port index, output, 4: current table entry.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, GAP, DONE, ERROR.
REQ-020 SHALL move IDLE/DONE/ERROR -> ISSUE on start=1 and, on that edge, clear index, retry count, done and error.
REQ-021 SHALL ignore start in ISSUE, WAIT and GAP.
REQ-022 SHALL assert txn_req only in ISSUE, holding txn_data stable until the handshake completes.
REQ-023 SHALL treat txn_req & txn_ready in one cycle as acceptance, entering WAIT on the next edge; txn_req SHALL be 0 in WAIT.
REQ-024 SHALL, in WAIT, on txn_done & !txn_nack with index == NUM_WRITES-1, go to DONE.
REQ-025 SHALL, in WAIT, on txn_done & !txn_nack with other index values, increment index, clear the retry count and go to GAP.
REQ-026 SHALL, in WAIT, on txn_done & txn_nack, increment the retry count.
REQ-027 SHALL go to ERROR when the incremented retry count equals MAX_RETRIES, keeping index unchanged.
REQ-028 SHALL otherwise go to GAP with index unchanged, so the same entry is retried.
REQ-029 SHALL count cycles in WAIT; TIMEOUT_CYCLES cycles without txn_done SHALL be handled exactly as a NACK.
REQ-030 SHALL ignore txn_done in any state other than WAIT.
REQ-031 SHALL stay in GAP exactly GAP_CYCLES cycles, then enter ISSUE.
REQ-032 SHALL drive busy=1 in ISSUE, WAIT and GAP only.
REQ-033 SHALL hold done=1 in DONE and error=1 in ERROR until the next start.
REQ-034 SHALL source txn_data combinationally from a table lookup of index; entries at index >= NUM_WRITES are 16'h0000 and never issued.
REQ-035 SHALL size the gap/timeout counter to hold TIMEOUT_CYCLES, with no wrap before expiry.

Reset
REQ-036 SHALL, on reset_n=0 and regardless of state (including mid-WAIT), immediately force IDLE, txn_req=0, busy=0, done=0, error=0, index=0, and clear the retry and cycle counters.
REQ-037 SHALL take no action at reset release until a new start.

Structure
REQ-038 SHALL place state encodings, the default PERIPH_ADDR and the init-table width constants in shared package i2c_pkg.
REQ-039 SHALL implement the table as sub-module i2c_init_rom (4-bit index in, 16-bit word out, purely combinational).

Verification
REQ-040 SHALL test a full run: start pulse with all ACK -> 10 accepted requests with index 0..9, GAP of 16 cycles between requests, done=1 and busy=0 one cycle after the 10th txn_done.
REQ-041 SHALL test ready stall: txn_ready=0 for 5 cycles -> txn_req and txn_data held constant, WAIT entered one edge after txn_ready=1.
REQ-042 SHALL test one NACK: NACK on entry 3 then ACK -> entry 3 reissued after the gap, index advances to 4, done reached.
REQ-043 SHALL test abort: NACK on entry 2 three times -> error=1, index=2, txn_req=0, no further requests.
REQ-044 SHALL test timeout: no txn_done for 4096 cycles on entry 0, three times -> error=1; an extra txn_done afterwards is ignored.
REQ-045 SHALL test reset mid-operation: reset_n low during WAIT on entry 5 -> all outputs at reset values; the next start begins at index 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C init sequencer slice: FSM state encoding,
// the default peripheral address and the init-table geometry.
// No ports (package).
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [6:0]  DEFAULT_PERIPH_ADDR = 7'h1A;
    localparam int unsigned ROM_INDEX_W         = 4;
    localparam int unsigned ROM_DATA_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_e;

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2c_init_sequencer_if
// Write-transaction handshake between the init sequencer and an I2C master.
//   txn_req   : sequencer requests a write
//   txn_ready : master can accept the request
//   txn_addr  : 7-bit target address
//   txn_data  : {reg byte, data byte}
//   txn_done  : one-cycle pulse when the transaction ends
//   txn_nack  : qualifies txn_done, 1 = NACK
// Modport master = sequencer side, slave = I2C master engine side.
// ---------------------------------------------------------------------------
interface i2c_init_sequencer_if;
    import i2c_pkg::*;

    logic                  txn_req;
    logic                  txn_ready;
    logic [6:0]            txn_addr;
    logic [ROM_DATA_W-1:0] txn_data;
    logic                  txn_done;
    logic                  txn_nack;

    modport master (
        output txn_req, txn_addr, txn_data,
        input  txn_ready, txn_done, txn_nack
    );

    modport slave (
        input  txn_req, txn_addr, txn_data,
        output txn_ready, txn_done, txn_nack
    );

endinterface

// File: rtl/i2c_init_rom.sv
// ---------------------------------------------------------------------------
// i2c_init_rom
// Purely combinational init table: {reg byte, data byte} per entry.
//   index_i : table entry (4 bits)
//   word_o  : table word; entries at or beyond NUM_WRITES read as zero
// ---------------------------------------------------------------------------
module i2c_init_rom
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_WRITES = 10
)(
    input  logic [ROM_INDEX_W-1:0] index_i,
    output logic [ROM_DATA_W-1:0]  word_o
);

    logic [ROM_DATA_W-1:0] rawWord;

    // Fixed codec bring-up table; unused tail entries are masked so a
    // shorter table never exposes stale words.
    always_comb begin
        rawWord = '0;
        case (index_i)
            4'd0:    rawWord = 16'h1E00;
            4'd1:    rawWord = 16'h0017;
            4'd2:    rawWord = 16'h0217;
            4'd3:    rawWord = 16'h0479;
            4'd4:    rawWord = 16'h0679;
            4'd5:    rawWord = 16'h0812;
            4'd6:    rawWord = 16'h0A00;
            4'd7:    rawWord = 16'h0C00;
            4'd8:    rawWord = 16'h0E42;
            4'd9:    rawWord = 16'h1001;
            4'd10:   rawWord = 16'h1201;
            4'd11:   rawWord = 16'h1400;
            4'd12:   rawWord = 16'h1600;
            4'd13:   rawWord = 16'h1800;
            4'd14:   rawWord = 16'h1A00;
            4'd15:   rawWord = 16'h1C00;
            default: rawWord = '0;
        endcase
        word_o = (32'(index_i) < NUM_WRITES) ? rawWord : '0;
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_init_sequencer
// Walks the init table, issuing one I2C write per entry with retry on NACK
// or timeout, an idle gap between transactions, and done/error status.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   start   : run the table (honoured only in IDLE/DONE/ERROR)
//   bus     : transaction handshake to the I2C master (master modport)
//   busy    : sequence in progress
//   done    : all entries acknowledged (held until next start)
//   error   : sequence aborted after MAX_RETRIES failures (held)
//   index   : current table entry
// ---------------------------------------------------------------------------
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter logic [6:0]  PERIPH_ADDR    = DEFAULT_PERIPH_ADDR,
    parameter int unsigned NUM_WRITES     = 10,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
)(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    i2c_init_sequencer_if.master   bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ROM_INDEX_W-1:0] index
);

    // One counter serves both the gap and the wait timeout, so it is
    // sized for whichever limit is larger.
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]       TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RETRY_W-1:0]     RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [ROM_INDEX_W-1:0] LAST_IDX     = ROM_INDEX_W'(NUM_WRITES - 1);

    seq_state_e             state_q, state_d;
    logic [ROM_INDEX_W-1:0] idx_q, idx_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_W-1:0]     retryInc;

    assign retryInc = retry_q + RETRY_W'(1);

    // State register; reset drops everything back to IDLE immediately,
    // even in the middle of an outstanding transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A timeout in WAIT takes the same path as a NACK,
    // so one retry budget covers both kinds of failure.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    retry_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (bus.txn_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (bus.txn_done && !bus.txn_nack) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ROM_INDEX_W'(1);
                        retry_d = '0;
                        state_d = ST_GAP;
                    end
                end else if (bus.txn_done || (cnt_q == TIMEOUT_LAST)) begin
                    cnt_d   = '0;
                    retry_d = retryInc;
                    state_d = (retryInc == RETRY_LIMIT) ? ST_ERROR : ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.txn_req  = (state_q == ST_ISSUE);
    assign bus.txn_addr = PERIPH_ADDR;
    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_GAP);
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign index        = idx_q;

    i2c_init_rom #(
        .NUM_WRITES (NUM_WRITES)
    ) u_rom (
        .index_i (idx_q),
        .word_o  (bus.txn_data)
    );

endmodule
